// File: rtl/fft_input_collector.sv
// fft_input_collector: serial-to-parallel ping-pong front end for the 8-point FFT datapath.
// Samples arrive one per clock and are assembled into 8-sample frames across two banks.
// One bank fills while the other is held on out1..out8 for the consumer.
// Optional macro FFT_IN_BITREV_EN: store samples in bit-reversed slot order for
// decimation-in-time; undefined gives natural order.
module fft_input_collector #(
  parameter int DATA_W = 8
) (
  input  logic              clk_1,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [DATA_W-1:0] out8,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [7:0]        frame_count
);

  logic [DATA_W-1:0] r_bank [2][8];
  logic [1:0]        r_full;
  logic              r_wb;
  logic              r_rb;
  logic [2:0]        r_wp;
  logic [7:0]        r_frameCount;

  logic              w_accept;
  logic              w_frameDone;
  logic              w_handoff;
  logic [2:0]        w_slot;

`ifdef FFT_IN_BITREV_EN
  assign w_slot = {r_wp[0], r_wp[1], r_wp[2]};
`else
  assign w_slot = r_wp;
`endif

  // Flush blocks acceptance so the discarded frame cannot pick up a stray sample.
  assign in_ready    = !r_full[r_wb] && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_frameDone = w_accept && (r_wp == 3'd7);
  assign frame_valid = r_full[r_rb];
  assign w_handoff   = frame_valid && frame_ready;
  assign frame_count = r_frameCount;

  assign out1 = r_bank[r_rb][0];
  assign out2 = r_bank[r_rb][1];
  assign out3 = r_bank[r_rb][2];
  assign out4 = r_bank[r_rb][3];
  assign out5 = r_bank[r_rb][4];
  assign out6 = r_bank[r_rb][5];
  assign out7 = r_bank[r_rb][6];
  assign out8 = r_bank[r_rb][7];

  // Write each accepted sample into its mapped slot of the bank currently filling.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 8; s++) begin
          r_bank[b][s] <= '0;
        end
      end
    end else if (w_accept) begin
      r_bank[r_wb][w_slot] <= in_data;
    end
  end

  // Bank bookkeeping: completion fills the write bank, handoff frees the read bank.
  // Both may happen in one cycle; they always target different banks.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_full       <= 2'b00;
      r_wb         <= 1'b0;
      r_rb         <= 1'b0;
      r_frameCount <= 8'd0;
    end else begin
      if (w_frameDone) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_handoff) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
        r_frameCount <= r_frameCount + 8'd1;
      end
    end
  end

  // Write pointer advances per accepted sample, wrapping naturally after slot 7.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= 3'd0;
    end else if (flush) begin
      r_wp <= 3'd0;
    end else if (w_accept) begin
      r_wp <= r_wp + 3'd1;
    end
  end

endmodule

// File: tb/tb_fft_input_collector.sv
// Self-checking bench for fft_input_collector: table-driven vectors plus
// hand-written multi-cycle sequences, scored against a queue of expected frames.
module tb_fft_input_collector;

  localparam int DATA_W = 8;

  typedef logic [8*DATA_W-1:0] frame_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       fl;
    logic       rdy;
    logic       expInReady;
    logic       expFrameValid;
    logic [7:0] expCount;
    logic       checkOut;
  } vec_t;

`ifdef FFT_IN_BITREV_EN
  localparam frame_t EXP_FIRST = 64'h0804060207030501;
`else
  localparam frame_t EXP_FIRST = 64'h0807060504030201;
`endif

  logic              clk_1 = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              flush = 1'b0;
  logic              frame_ready = 1'b0;
  logic              in_ready;
  logic              frame_valid;
  logic [7:0]        frame_count;
  logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8;
  frame_t            outBus;

  int     checks = 0;
  int     passed = 0;
  frame_t expFrames[$];
  frame_t curFrame = '0;
  int     curCount = 0;
  int     modelCount = 0;
  vec_t   vecs[10];

  assign outBus = {out8, out7, out6, out5, out4, out3, out2, out1};

  fft_input_collector #(.DATA_W(DATA_W)) dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .out4        (out4),
    .out5        (out5),
    .out6        (out6),
    .out7        (out7),
    .out8        (out8),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_count (frame_count)
  );

  // Free-running system clock, 10 time-unit period.
  always #5 clk_1 = ~clk_1;

  function automatic logic [2:0] mapSlot(input int k);
    logic [2:0] w;
    w = k[2:0];
`ifdef FFT_IN_BITREV_EN
    return {w[0], w[1], w[2]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic expReady;
    expReady = (expFrames.size() < 2) && !flush;
    check({tag, " in_ready"}, 64'(in_ready), 64'(expReady));
    check({tag, " frame_valid"}, 64'(frame_valid), 64'(expFrames.size() > 0));
    check({tag, " frame_count"}, 64'(frame_count), 64'(modelCount[7:0]));
    if (expFrames.size() > 0) check({tag, " frame data"}, outBus, expFrames[0]);
  endtask

  task automatic driveInputs(input logic v, input logic [7:0] d, input logic fl, input logic rdy);
    @(negedge clk_1);
    in_valid    = v;
    in_data     = d;
    flush       = fl;
    frame_ready = rdy;
  endtask

  task automatic finishCycle(input string tag);
    bit acc;
    bit hand;
    #1;
    checkOutput(tag);
    acc  = in_valid && !flush && (expFrames.size() < 2);
    hand = frame_ready && (expFrames.size() > 0);
    @(posedge clk_1);
    if (flush) curCount = 0;
    if (hand) begin
      void'(expFrames.pop_front());
      modelCount++;
    end
    if (acc) begin
      curFrame[8*mapSlot(curCount) +: 8] = in_data;
      curCount++;
      if (curCount == 8) begin
        expFrames.push_back(curFrame);
        curCount = 0;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input logic v, input logic [7:0] d,
                               input logic fl, input logic rdy);
    driveInputs(v, d, fl, rdy);
    finishCycle(tag);
  endtask

  // Main test sequence.
  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};
    end
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0};

    // Reset then idle.
    #12;
    check("reset outs", outBus, 64'd0);
    check("reset frame_valid", 64'(frame_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset frame_count", 64'(frame_count), 64'd0);
    @(negedge clk_1);
    rst_n = 1'b1;
    applyStimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Single frame 0x01..0x08 then one handoff.
    for (int i = 0; i < 10; i++) begin
      driveInputs(vecs[i].valid, vecs[i].data, vecs[i].fl, vecs[i].rdy);
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].expInReady));
      check($sformatf("vec%0d frame_valid", i), 64'(frame_valid), 64'(vecs[i].expFrameValid));
      check($sformatf("vec%0d frame_count", i), 64'(frame_count), 64'(vecs[i].expCount));
      if (vecs[i].checkOut) check($sformatf("vec%0d outs", i), outBus, EXP_FIRST);
      finishCycle($sformatf("vec%0d", i));
    end

    // Back-pressure: 24 samples offered with the consumer stalled.
    for (int i = 0; i < 24; i++) begin
      applyStimulus($sformatf("bp%0d", i), 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    end
    driveInputs(1'b1, 8'h77, 1'b0, 1'b0);
    #1;
    check("bp both full in_ready", 64'(in_ready), 64'd0);
    finishCycle("bp hold");
    applyStimulus("bp pulse", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus("bp second", 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("bp drain", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus("bp idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Full throughput with the consumer always ready (simultaneous fill/handoff).
    for (int i = 0; i < 24; i++) begin
      applyStimulus($sformatf("tp%0d", i), 1'b1, 8'(8'h80 + 3 * i), 1'b0, 1'b1);
    end
    applyStimulus("tp drain", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus("tp idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Flush a partial frame, then a clean frame 0x10..0x17.
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("pre%0d", i), 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    end
    applyStimulus("flush", 1'b1, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("post%0d", i), 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    end
    driveInputs(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    check("flush frame natural slot0", 64'(out1), 64'h10);
    finishCycle("flush take");
    applyStimulus("flush idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("mr%0d", i), 1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
    end
    @(negedge clk_1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outs", outBus, 64'd0);
    check("async reset frame_count", 64'(frame_count), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    expFrames.delete();
    curCount   = 0;
    modelCount = 0;
    curFrame   = '0;
    @(negedge clk_1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("ar%0d", i), 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    end
    applyStimulus("ar take", 1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus("ar idle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
